// File: rtl/swap_countdown.sv
// Countdown engine: loads N into X/Y, then steps Y and X down alternately to zero.
// Y is never allowed above X; a swap repair path flags err if that ever happens.
module swap_countdown #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] start_val,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] x_out,
  output logic [W-1:0] y_out,
  output logic [W:0]   steps,
  output logic         err,
  output logic         prop
);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DONE
  } state_t;

  state_t       state, state_d;
  logic [W-1:0] x, x_d;
  logic [W-1:0] y, y_d;
  logic [W:0]   cnt, cnt_d;
  logic         err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_d;
      x     <= x_d;
      y     <= y_d;
      cnt   <= cnt_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    state_d = state;
    x_d     = x;
    y_d     = y;
    cnt_d   = cnt;
    err_d   = err_q;
    unique case (state)
      IDLE: begin
        if (start) begin
          x_d     = start_val;
          y_d     = start_val;
          cnt_d   = '0;
          state_d = COUNT;
        end
      end
      COUNT: begin
        // Row order matters: zero exit first, then repair, then the two steps.
        if (x == '0 && y == '0) begin
          state_d = DONE;
        end else if (y > x) begin
          x_d   = y;
          y_d   = x;
          err_d = 1'b1;
        end else if (x == y) begin
          y_d   = y - W'(1);
          cnt_d = cnt + (W+1)'(1);
        end else begin
          x_d   = x - W'(1);
          cnt_d = cnt + (W+1)'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ready = (state == IDLE);
  assign busy  = (state == COUNT);
  assign done  = (state == DONE);
  assign x_out = x;
  assign y_out = y;
  assign steps = cnt;
  assign err   = err_q;
  assign prop  = !(y > x);

  assert property (@(posedge clk) disable iff (rst) prop);

endmodule
